// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer for the shared-ROM FIR band filters.
// Owns the circular sample-buffer write pointer, the initial buffer fill,
// and one convolution pass (NUM_TAPS+1 cycles of 'sequencing') per sample.
// Optional feature macro: FIR_SEQ_STATS_EN adds pass_cnt / ovr_cnt outputs.
module fir_seq_ctrl #(
  parameter int NUM_TAPS = 1021,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_vld,
  input  logic              flush,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              sequencing,
  output logic              conv_done,
  output logic              busy,
  output logic              overrun
`ifdef FIR_SEQ_STATS_EN
  ,
  output logic [15:0]       pass_cnt,
  output logic [7:0]        ovr_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0]  LAST_K    = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0]  LAST_RD_K = CNT_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] TAPS_A    = ADDR_W'(NUM_TAPS);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_IDLE,
    ST_SEQ,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0]  r_fill_cnt;
  logic [CNT_W-1:0]  w_fill_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic              r_overrun;
  logic              w_ovr_evt;
  logic              w_enter_seq;
  logic [CNT_W-1:0]  r_k;
  logic [ADDR_W-1:0] r_rd_addr;

  // The write pointer advances on every accepted sample, in every state.
  assign w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(smpl_vld);

  // Next-state, fill count and pending/overrun decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill_cnt;
    w_pending_nxt = r_pending;
    w_ovr_evt     = 1'b0;
    w_enter_seq   = 1'b0;

    case (r_state)
      ST_FILL: begin
        if (smpl_vld) begin
          if (r_fill_cnt != LAST_K) w_fill_nxt = r_fill_cnt + 1'b1;
          if (r_fill_cnt == LAST_RD_K) w_enter_seq = 1'b1;
        end
      end
      ST_IDLE: begin
        if (smpl_vld || r_pending) w_enter_seq = 1'b1;
      end
      ST_SEQ: begin
        if (r_k == LAST_K) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (r_pending) w_enter_seq = 1'b1;
        else           w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_FILL;
    endcase

    // Outside FILL a sample either queues one more pass or, if one is
    // already queued, is only written and flagged as an overrun.
    if (smpl_vld && (r_state != ST_FILL)) begin
      if (r_pending) w_ovr_evt     = 1'b1;
      else           w_pending_nxt = 1'b1;
    end

    if (w_enter_seq) begin
      w_state_nxt   = ST_SEQ;
      w_pending_nxt = 1'b0;
    end

    // Flush discards history; the RAM write itself still happens.
    if (flush) begin
      w_state_nxt   = ST_FILL;
      w_fill_nxt    = '0;
      w_pending_nxt = 1'b0;
      w_ovr_evt     = 1'b0;
      w_enter_seq   = 1'b0;
    end
  end

  // State, write pointer, fill count, pending and sticky overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_pending  <= w_pending_nxt;
      if (flush)          r_overrun <= 1'b0;
      else if (w_ovr_evt) r_overrun <= 1'b1;
    end
  end

  // Pass tap counter and read address: base latched on entry, then walks
  // NUM_TAPS addresses and holds the last one for the final tap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_rd_addr <= '0;
    end else if (w_enter_seq) begin
      r_k       <= '0;
      r_rd_addr <= w_wr_ptr_nxt - TAPS_A;
    end else if (r_state == ST_SEQ) begin
      if (r_k != LAST_K)    r_k       <= r_k + 1'b1;
      if (r_k < LAST_RD_K)  r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

  assign buf_we      = smpl_vld;
  assign buf_wr_addr = r_wr_ptr;
  assign buf_rd_addr = r_rd_addr;
  assign sequencing  = (r_state == ST_SEQ);
  assign busy        = (r_state == ST_SEQ);
  assign conv_done   = (r_state == ST_DONE);
  assign overrun     = r_overrun;

`ifdef FIR_SEQ_STATS_EN
  logic [15:0] r_pass_cnt;
  logic [7:0]  r_ovr_cnt;

  // Completed-pass counter (wrapping) and overrun-event counter (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_ovr_cnt  <= '0;
    end else if (flush) begin
      r_pass_cnt <= '0;
      r_ovr_cnt  <= '0;
    end else begin
      if (r_state == ST_DONE) r_pass_cnt <= r_pass_cnt + 1'b1;
      if (w_ovr_evt && (r_ovr_cnt != 8'hFF)) r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign ovr_cnt  = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed and randomized bench for fir_seq_ctrl
// (NUM_TAPS=8, ADDR_W=4) against an event-level reference model.
// Build with FIR_SEQ_STATS_EN defined to also check pass_cnt / ovr_cnt.
module tb_fir_seq_ctrl;

  localparam int N     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          smpl_vld = 1'b0;
  logic          flush = 1'b0;
  logic          buf_we;
  logic [AW-1:0] buf_wr_addr;
  logic [AW-1:0] buf_rd_addr;
  logic          sequencing;
  logic          conv_done;
  logic          busy;
  logic          overrun;
`ifdef FIR_SEQ_STATS_EN
  logic [15:0]   pass_cnt;
  logic [7:0]    ovr_cnt;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  fir_seq_ctrl #(.NUM_TAPS(N), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .smpl_vld    (smpl_vld),
    .flush       (flush),
    .buf_we      (buf_we),
    .buf_wr_addr (buf_wr_addr),
    .buf_rd_addr (buf_rd_addr),
    .sequencing  (sequencing),
    .conv_done   (conv_done),
    .busy        (busy),
    .overrun     (overrun)
`ifdef FIR_SEQ_STATS_EN
    ,
    .pass_cnt    (pass_cnt),
    .ovr_cnt     (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: buffer fill, pass progress, queued pass, overrun.
  typedef struct {
    int wr;       // write pointer, 0..DEPTH-1
    int fill;     // samples written since reset/flush, saturating at N
    bit filling;  // still collecting the first N samples
    int k;        // tap index of the active pass, -1 when none
    bit done;     // this cycle reports the end of a pass
    bit pend;     // a further pass is queued
    bit ovr;      // sticky overrun flag
    int base;     // first read address of the active pass
    int passes;   // completed passes, mod 65536
    int ovrs;     // overrun events, saturating at 255
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.wr = 0; r.fill = 0; r.filling = 1'b1; r.k = -1; r.done = 1'b0;
    r.pend = 1'b0; r.ovr = 1'b0; r.base = 0; r.passes = 0; r.ovrs = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, bit sv, bit fl);
    model_t n = m;
    bit start = 1'b0;
    n.wr = (m.wr + int'(sv)) % DEPTH;
    n.done = 1'b0;
    if (fl) begin
      n.fill = 0; n.filling = 1'b1; n.k = -1; n.pend = 1'b0; n.ovr = 1'b0;
      n.passes = 0; n.ovrs = 0;
      return n;
    end
    if (m.done) n.passes = (m.passes + 1) % 65536;
    if (m.filling) begin
      if (sv && m.fill < N) begin
        n.fill = m.fill + 1;
        if (n.fill == N) begin
          start = 1'b1;
          n.filling = 1'b0;
        end
      end
    end else begin
      if (sv) begin
        if (m.pend) begin
          n.ovr = 1'b1;
          if (m.ovrs < 255) n.ovrs = m.ovrs + 1;
        end else begin
          n.pend = 1'b1;
        end
      end
      if (m.k >= 0) begin
        if (m.k == N) begin
          n.k = -1;
          n.done = 1'b1;
        end else begin
          n.k = m.k + 1;
        end
      end else if (m.done) begin
        start = m.pend;
      end else begin
        start = sv || m.pend;
      end
    end
    if (start) begin
      n.pend = 1'b0;
      n.k = 0;
      n.base = (n.wr - N + DEPTH) % DEPTH;
    end
    return n;
  endfunction

  model_t m = model_reset();

  // Advance the model on each clock edge; asynchronous reset clears it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, smpl_vld, flush);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("buf_we", 32'(buf_we), 32'(smpl_vld));
      check("wr_addr", 32'(buf_wr_addr), 32'(m.wr));
      check("sequencing", 32'(sequencing), 32'(m.k >= 0));
      check("busy", 32'(busy), 32'(m.k >= 0));
      check("conv_done", 32'(conv_done), 32'(m.done));
      check("overrun", 32'(overrun), 32'(m.ovr));
      if (m.k >= 0)
        check("rd_addr", 32'(buf_rd_addr), 32'((m.base + ((m.k < N) ? m.k : N - 1)) % DEPTH));
`ifdef FIR_SEQ_STATS_EN
      check("pass_cnt", 32'(pass_cnt), 32'(m.passes));
      check("ovr_cnt", 32'(ovr_cnt), 32'(m.ovrs));
`endif
      if (conv_done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((sequencing || conv_done) && n < limit) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(sequencing || conv_done), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] rdv [0:19];
    int n;
    int d0;

    tick();
    chk_en = 1'b1;
    tick();
    check("rst_seq", 32'(sequencing), 32'd0);
    check("rst_done", 32'(conv_done), 32'd0);
    check("rst_wr", 32'(buf_wr_addr), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Initial fill: seven samples do not start a pass, the eighth does.
    repeat (7) begin
      strobe();
      tick();
    end
    check("fill7_seq", 32'(sequencing), 32'd0);
    strobe();
    check("fill8_seq", 32'(sequencing), 32'd1);
    n = 0;
    while (sequencing && n < 20) begin
      rdv[n] = buf_rd_addr;
      n++;
      tick();
    end
    check("fill_seq_len", 32'(n), 32'd9);
    for (int i = 0; i < 9; i++)
      check("fill_rd", 32'(rdv[i]), 32'((i < 8) ? i : 7));
    check("fill_done", 32'(conv_done), 32'd1);
    tick();
    check("fill_done_1cyc", 32'(conv_done), 32'd0);

    // Steady state: one sample every 20 cycles, base advances by one.
    d0 = done_cnt;
    for (int j = 0; j < 14; j++) begin
      strobe();
      check("steady_seq", 32'(sequencing), 32'd1);
      check("steady_base", 32'(buf_rd_addr), 32'((1 + j) % DEPTH));
      if (j == 12) begin
        repeat (3) tick();
        check("wrap_rd", 32'(buf_rd_addr), 32'd0);
        repeat (16) tick();
      end else begin
        repeat (19) tick();
      end
    end
    check("steady_passes", 32'(done_cnt - d0), 32'd14);

    // Overlap: sample at k=3 queues a pass, sample at k=5 overruns.
    strobe();
    repeat (3) tick();
    strobe();
    tick();
    strobe();
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (3) tick();
    check("ovl_done", 32'(conv_done), 32'd1);
    tick();
    check("ovl_back2back", 32'(sequencing), 32'd1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    wait_idle(30);

    // Flush at k=4 aborts the pass and requires a full refill.
    strobe();
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_seq", 32'(sequencing), 32'd0);
    check("flush_ovr", 32'(overrun), 32'd0);
`ifdef FIR_SEQ_STATS_EN
    check("flush_pass_cnt", 32'(pass_cnt), 32'd0);
    check("flush_ovr_cnt", 32'(ovr_cnt), 32'd0);
`endif
    d0 = done_cnt;
    repeat (12) tick();
    check("flush_no_done", 32'(done_cnt - d0), 32'd0);
    repeat (7) begin
      strobe();
      tick();
    end
    check("refill7_seq", 32'(sequencing), 32'd0);
    strobe();
    check("refill8_seq", 32'(sequencing), 32'd1);
    wait_idle(30);

    // Asynchronous reset in the middle of a pass.
    strobe();
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_seq", 32'(sequencing), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wr", 32'(buf_wr_addr), 32'd0);
    check("arst_rd", 32'(buf_rd_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    check("arst_wr_rel", 32'(buf_wr_addr), 32'd0);
    strobe();
    check("arst_fill", 32'(sequencing), 32'd0);
    check("arst_wr_inc", 32'(buf_wr_addr), 32'd1);

    // Randomized traffic at several sample densities, with rare flushes.
    for (int ph = 0; ph < 3; ph++) begin
      int pct;
      pct = (ph == 0) ? 5 : ((ph == 1) ? 15 : 40);
      for (int c = 0; c < 1000; c++) begin
        smpl_vld = ($urandom_range(0, 99) < pct);
        flush = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    smpl_vld = 1'b0;
    flush = 1'b0;
    repeat (25) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
